// File: rtl/div_radix2.sv
`default_nettype none
//==============================================================================
// Module      : div_radix2
// Description : Multi-cycle radix-2 restoring divider for the EX stage, used by
//               MIPS DIV (signed) and DIVU (unsigned). One quotient bit per
//               clock; result = {remainder, quotient} goes to HI/LO.
// Ports       :
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   start       - divide request from the hazard unit (div_start)
//   signed_div  - 1 = DIV (signed), 0 = DIVU
//   opdata1     - dividend (rs)
//   opdata2     - divisor (rt)
//   annul       - abort current operation (exception flush)
//   ready       - one-cycle result-valid pulse (div_ready)
//   result      - {remainder, quotient}
// Revision    : 1.0 - initial release
//==============================================================================
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int                CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DZERO = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_dividend;     // original dividend, needed for /0 result
    logic [WIDTH-1:0]   r_divisor;      // divisor magnitude
    logic [WIDTH-1:0]   r_rem;          // partial remainder
    logic [WIDTH-1:0]   r_quo;          // dividend bits shifting out, quotient bits in
    logic               r_qsign;
    logic               r_rsign;
    logic [2*WIDTH-1:0] r_result;

    // Operand magnitudes. The WIDTH-bit negate leaves the most negative value
    // unchanged, which is exactly its unsigned magnitude.
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_a_neg = signed_div & opdata1[WIDTH-1];
    assign w_b_neg = signed_div & opdata2[WIDTH-1];
    assign w_a_mag = w_a_neg ? -opdata1 : opdata1;
    assign w_b_mag = w_b_neg ? -opdata2 : opdata2;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // with one extra bit so the borrow shows up as the sign.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_rem_final;
    logic [WIDTH-1:0]   w_quo_final;

    assign w_shift     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_trial[WIDTH];
    assign w_rem_step  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_step  = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_final = r_qsign ? -w_quo_step : w_quo_step;
    assign w_rem_final = r_rsign ? -w_rem_step : w_rem_step;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; annul overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (annul) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_next = (opdata2 == '0) ? ST_DZERO : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_count == C_LAST) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DZERO: w_state_next = ST_DONE;
                ST_DONE:  w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_qsign    <= 1'b0;
            r_rsign    <= 1'b0;
            r_result   <= '0;
        end else if (!annul) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dividend <= opdata1;
                        r_divisor  <= w_b_mag;
                        r_quo      <= w_a_mag;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_qsign    <= w_a_neg ^ w_b_neg;
                        r_rsign    <= w_a_neg;
                    end
                end
                ST_BUSY: begin
                    r_rem   <= w_rem_step;
                    r_quo   <= w_quo_step;
                    r_count <= r_count + C_ONE;
                    if (r_count == C_LAST) begin
                        r_result <= {w_rem_final, w_quo_final};
                    end
                end
                ST_DZERO: begin
                    r_result <= {r_dividend, {WIDTH{1'b1}}};
                end
                default: begin
                end
            endcase
        end
    end

    assign ready  = (r_state == ST_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_radix2.sv
`default_nettype none
//==============================================================================
// Module      : tb_div_radix2
// Description : Directed self-checking bench for div_radix2 (WIDTH = 32).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        ready;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    div_radix2 #(.WIDTH(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, hold start until ready is seen (as the hazard unit
    // does), scramble the operands after acceptance, then check latency,
    // pulse count and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input int exp_lat, input logic [63:0] exp_res);
        int first;
        int pulses;
        @(negedge clk);
        start = 1'b1; opdata1 = a; opdata2 = b; signed_div = sg;
        @(posedge clk);                     // cycle T: accepted
        first  = -1;
        pulses = 0;
        for (int n = 1; n <= exp_lat + 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                opdata1 = ~a; opdata2 = 32'h3; signed_div = ~sg;
            end
            if (ready) begin
                pulses++;
                if (first < 0) first = n;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(first), 64'(exp_lat));
        check({tag, " pulses"}, 64'(pulses), 64'd1);
        check({tag, " result"}, result, exp_res);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0; annul = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("u 100/7",       32'd100,       32'd7,          1'b0, 33, {32'h00000002, 32'h0000000E});
        run_op("s -7/2",        32'hFFFFFFF9,  32'h00000002,   1'b1, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("s 7/-2",        32'h00000007,  32'hFFFFFFFE,   1'b1, 33, {32'h00000001, 32'hFFFFFFFD});
        run_op("s -100/-7",     32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, 33, {32'hFFFFFFFE, 32'h0000000E});
        run_op("u FFFFFFF9/2",  32'hFFFFFFF9,  32'h00000002,   1'b0, 33, {32'h00000001, 32'h7FFFFFFC});
        run_op("s min/-1",      32'h80000000,  32'hFFFFFFFF,   1'b1, 33, {32'h00000000, 32'h80000000});
        run_op("u max/1",       32'hFFFFFFFF,  32'h00000001,   1'b0, 33, {32'h00000000, 32'hFFFFFFFF});
        run_op("u 5/0",         32'd5,         32'd0,          1'b0, 2,  {32'h00000005, 32'hFFFFFFFF});
        run_op("s -5/0",        32'hFFFFFFFB,  32'd0,          1'b1, 2,  {32'hFFFFFFFB, 32'hFFFFFFFF});

        // Annul during BUSY: no ready pulse, result unchanged
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("annul pulses", 64'(pulses), 64'd0);
        check("annul result", result, {32'hFFFFFFFB, 32'hFFFFFFFF});
        run_op("u 9/3 after annul", 32'd9, 32'd3, 1'b0, 33, {32'h00000000, 32'h00000003});

        // annul together with start in IDLE: start ignored
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd0;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("annul+start pulses", 64'(pulses), 64'd0);

        // Asynchronous reset between clock edges in the middle of BUSY
        @(negedge clk);
        start = 1'b1; opdata1 = 32'd1000; opdata2 = 32'd10; signed_div = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst ready", 64'(ready), 64'd0);
        check("async rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("rst no pulse", 64'(pulses), 64'd0);
        run_op("u 1000/10 after rst", 32'd1000, 32'd10, 1'b0, 33, {32'h00000000, 32'h00000064});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
